mipi_rx_byte_aligner: RTL and testbench

//  Sits between the lane-0 deserializer and frame_detector. Hunts each HS burst for the
//  CSI-2 sync byte 8'hB8 at any bit offset, locks that offset, and emits byte-aligned data

---
 rtl/mipi_rx_byte_aligner.sv | 113 +++++++++++
 tb/tb_mipi_rx_byte_aligner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_byte_aligner.sv
// Lane-0 byte aligner: hunts each HS burst for the sync byte at any bit offset,
// locks that offset and emits byte-aligned data framed by data_valid_o.
module mipi_rx_byte_aligner #(
    parameter int                    MIPI_GEAR    = 8,
    parameter logic [MIPI_GEAR-1:0]  SYNC_BYTE    = 8'hB8,
    parameter int                    SYNC_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 hs_valid_i,
    input  logic [MIPI_GEAR-1:0] byte_i,
    output logic                 data_valid_o,
    output logic [MIPI_GEAR-1:0] data_o,
    output logic                 locked_o,
    output logic [2:0]           offset_o,
    output logic                 sync_err_o,
    output logic [7:0]           sync_err_cnt_o
);

    // Handshake: data_valid_o is a pure valid (no ready); frame_detector must accept
    // every cycle data_valid_o=1. hs_valid_i qualifies byte_i in the same cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t                 state;
    logic [MIPI_GEAR-1:0]   prev;
    logic [7:0]             hunt_cnt;
    logic [2*MIPI_GEAR-1:0] win;
    logic                   match_found;
    logic [2:0]             match_k;
    logic [MIPI_GEAR-1:0]   aligned;

    // Older byte sits in the low half, so bit 0 of the window is earliest on the wire.
    assign win     = {byte_i, prev};
    assign aligned = win[{1'b0, offset_o} +: MIPI_GEAR];

    // Scan downwards so the lowest matching offset is the one left standing.
    always_comb begin
        match_found = 1'b0;
        match_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (win[4'(k) +: MIPI_GEAR] == SYNC_BYTE) begin
                match_found = 1'b1;
                match_k     = 3'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            prev           <= '0;
            hunt_cnt       <= '0;
            data_valid_o   <= 1'b0;
            data_o         <= '0;
            locked_o       <= 1'b0;
            offset_o       <= 3'd0;
            sync_err_o     <= 1'b0;
            sync_err_cnt_o <= 8'd0;
        end else begin
            sync_err_o <= 1'b0;
            if (!hs_valid_i) begin
                // End of burst wins over any match this cycle; offset_o is kept.
                state        <= IDLE;
                prev         <= '0;
                hunt_cnt     <= '0;
                data_valid_o <= 1'b0;
                locked_o     <= 1'b0;
            end else begin
                prev <= byte_i;
                case (state)
                    IDLE: begin
                        state <= HUNT;
                    end
                    HUNT: begin
                        if (match_found) begin
                            state        <= LOCKED;
                            offset_o     <= match_k;
                            locked_o     <= 1'b1;
                            data_o       <= SYNC_BYTE;
                            data_valid_o <= 1'b1;
                        end else begin
                            hunt_cnt <= hunt_cnt + 8'd1;
                            if (hunt_cnt == 8'(SYNC_TIMEOUT - 1)) begin
                                state      <= ERROR;
                                sync_err_o <= 1'b1;
                                if (sync_err_cnt_o != 8'hFF) begin
                                    sync_err_cnt_o <= sync_err_cnt_o + 8'd1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        data_o       <= aligned;
                        data_valid_o <= 1'b1;
                    end
                    ERROR: begin
                        data_valid_o <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_rx_byte_aligner.sv
// Bench for mipi_rx_byte_aligner: bursts are built as bit streams and the expected
// aligned bytes are read straight out of the stream by a bit-position model.
module tb_mipi_rx_byte_aligner;

    localparam logic [7:0] SYNC    = 8'hB8;
    localparam int         TIMEOUT = 16;

    logic       clk_i      = 1'b0;
    logic       reset_n_i  = 1'b0;
    logic       hs_valid_i = 1'b0;
    logic [7:0] byte_i     = 8'd0;
    logic       data_valid_o;
    logic [7:0] data_o;
    logic       locked_o;
    logic [2:0] offset_o;
    logic       sync_err_o;
    logic [7:0] sync_err_cnt_o;

    mipi_rx_byte_aligner #(
        .MIPI_GEAR   (8),
        .SYNC_BYTE   (SYNC),
        .SYNC_TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .hs_valid_i    (hs_valid_i),
        .byte_i        (byte_i),
        .data_valid_o  (data_valid_o),
        .data_o        (data_o),
        .locked_o      (locked_o),
        .offset_o      (offset_o),
        .sync_err_o    (sync_err_o),
        .sync_err_cnt_o(sync_err_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / model state ----------------
    logic [7:0] burst_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rises, err_pulses, lock_bad;
    logic       prev_valid = 1'b0;
    int         model_err_cnt = 0;
    logic [2:0] model_off = 3'd0;
    logic [7:0] model_data = 8'd0;

    always @(negedge clk_i) begin
        if (data_valid_o === 1'b1) begin
            got_q.push_back(data_o);
            if (!prev_valid) rises++;
            if (locked_o !== 1'b1) lock_bad++;
        end
        if (sync_err_o === 1'b1) err_pulses++;
        prev_valid = (data_valid_o === 1'b1);
    end

    // Byte of the burst bit stream starting at bit position p (bit 0 first on wire).
    function automatic logic [7:0] get_byte(input int p);
        logic [7:0] r, t;
        r = 8'd0;
        for (int j = 0; j < 8; j++) begin
            if ((p + j) / 8 < burst_q.size()) begin
                t    = burst_q[(p + j) / 8];
                r[j] = t[(p + j) % 8];
            end
        end
        return r;
    endfunction

    task automatic put_byte(input int pos, input logic [7:0] val);
        logic [7:0] t;
        for (int j = 0; j < 8; j++) begin
            if ((pos + j) / 8 < burst_q.size()) begin
                t                     = burst_q[(pos + j) / 8];
                t[(pos + j) % 8]      = val[j];
                burst_q[(pos + j) / 8] = t;
            end
        end
    endtask

    // fill: 0 zeros, 1 random, 2 alternating 0x55
    task automatic build_burst(input int n, input int fill);
        burst_q.delete();
        for (int i = 0; i < n; i++) begin
            case (fill)
                0:       burst_q.push_back(8'h00);
                1:       burst_q.push_back(8'($urandom));
                default: burst_q.push_back(8'h55);
            endcase
        end
    endtask

    // ---------------- driver + burst-level comparison ----------------
    task automatic run_burst(input string tag);
        int n, limit, p_found, exp_pulses;
        n          = burst_q.size();
        p_found    = -1;
        exp_pulses = 0;
        // Hunting sees aligned bytes that end before the last byte of the burst,
        // and only within the first TIMEOUT hunting bytes.
        limit = 8 * (n - 1);
        if (limit > 8 * TIMEOUT) limit = 8 * TIMEOUT;
        for (int p = 0; p < limit; p++) begin
            if (p_found < 0 && get_byte(p) == SYNC) p_found = p;
        end
        exp_q.delete();
        if (p_found >= 0) begin
            for (int s = p_found; s < 8 * (n - 1); s += 8) exp_q.push_back(get_byte(s));
            model_off  = 3'(p_found % 8);
            model_data = exp_q[exp_q.size() - 1];
        end else if (n - 1 >= TIMEOUT) begin
            exp_pulses = 1;
            if (model_err_cnt < 255) model_err_cnt++;
        end

        got_q.delete();
        rises = 0; err_pulses = 0; lock_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            hs_valid_i = 1'b1;
            byte_i     = burst_q[i];
        end
        @(negedge clk_i);
        hs_valid_i = 1'b0;
        byte_i     = 8'($urandom);
        @(negedge clk_i);
        @(negedge clk_i);

        check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s.data[%0d]", tag, i), got_q[i], exp_q[i]);
        check($sformatf("%s.rises", tag), rises, (p_found >= 0) ? 1 : 0);
        check($sformatf("%s.lock_during_valid", tag), lock_bad, 0);
        check($sformatf("%s.err_pulses", tag), err_pulses, exp_pulses);
        check($sformatf("%s.err_cnt", tag), sync_err_cnt_o, model_err_cnt);
        check($sformatf("%s.offset", tag), offset_o, model_off);
        check($sformatf("%s.idle_valid", tag), data_valid_o, 0);
        check($sformatf("%s.idle_locked", tag), locked_o, 0);
        check($sformatf("%s.data_hold", tag), data_o, model_data);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.valid", tag), data_valid_o, 0);
        check($sformatf("%s.data", tag), data_o, 0);
        check($sformatf("%s.locked", tag), locked_o, 0);
        check($sformatf("%s.offset", tag), offset_o, 0);
        check($sformatf("%s.err", tag), sync_err_o, 0);
        check($sformatf("%s.err_cnt", tag), sync_err_cnt_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Sync in the second byte, offset 0.
        burst_q.delete();
        burst_q = '{8'h00, 8'hB8, 8'h00, 8'h2C, 8'h01, 8'h00};
        run_burst("off0");

        // Same payload shifted by every bit offset.
        for (int k = 0; k < 8; k++) begin
            build_burst(7, 0);
            put_byte(8 + k, SYNC);
            put_byte(16 + k, 8'h01);
            put_byte(24 + k, 8'h23);
            put_byte(32 + k, 8'h45);
            put_byte(40 + k, 8'h67);
            run_burst($sformatf("sweep%0d", k));
        end

        build_burst(20, 2);
        run_burst("timeout55");

        // Lock on the very last hunting byte, then one bit too late.
        build_burst(20, 0);
        put_byte(123, SYNC);
        run_burst("late_lock");
        build_burst(20, 0);
        put_byte(128, SYNC);
        run_burst("too_late");

        // Five aligned bytes at offset 2, then a new burst relocks at offset 5.
        build_burst(6, 1);
        put_byte(2, SYNC);
        run_burst("end_off2");
        build_burst(6, 1);
        put_byte(5, SYNC);
        run_burst("relock_off5");

        // Degenerate short bursts.
        build_burst(1, 1);
        run_burst("len1");
        build_burst(2, 0);
        put_byte(0, SYNC);
        run_burst("len2_sync");

        for (int b = 0; b < 60; b++) begin
            int n;
            n = $urandom_range(1, 24);
            build_burst(n, $urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) put_byte($urandom_range(0, 8 * n - 1), SYNC);
            run_burst($sformatf("rand%0d", b));
        end

        // Async reset while locked, checked between clock edges.
        build_burst(10, 1);
        put_byte(10, SYNC);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            hs_valid_i = 1'b1;
            byte_i     = burst_q[i];
        end
        @(negedge clk_i);
        check("pre_reset.locked", locked_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        hs_valid_i = 1'b0;
        model_err_cnt = 0;
        model_off     = 3'd0;
        model_data    = 8'd0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        build_burst(9, 1);
        put_byte(19, SYNC);
        run_burst("after_reset");

        // Saturation of the timeout counter.
        for (int b = 0; b < 300; b++) begin
            build_burst(17, 0);
            run_burst($sformatf("sat%0d", b));
        end
        check("sat_final", sync_err_cnt_o, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
